// File: rtl/pa_bmu_req_arb.sv
// Two-master (IFU/LSU) arbiter sharing the single BMU transaction channel.
// LSU has default priority; a starvation counter and an INCR4 burst lock shape the choice.
module pa_bmu_req_arb #(
  parameter int unsigned LSU_MAX_CONSEC = 4
) (
  input  logic        bmu_clk,
  input  logic        cpurst_b,
  input  logic        ifu_bmu_req,
  input  logic [31:0] ifu_bmu_addr,
  input  logic [3:0]  ifu_bmu_prot,
  input  logic [1:0]  ifu_bmu_size,
  input  logic [2:0]  ifu_bmu_burst,
  input  logic        ifu_bmu_seq,
  input  logic        lsu_bmu_req,
  input  logic [31:0] lsu_bmu_addr,
  input  logic [3:0]  lsu_bmu_prot,
  input  logic [1:0]  lsu_bmu_size,
  input  logic [2:0]  lsu_bmu_burst,
  input  logic        lsu_bmu_seq,
  input  logic        lsu_bmu_write,
  input  logic [31:0] lsu_bmu_wdata,
  input  logic        lsu_bmu_acc_deny,
  input  logic        bmu_tt_grant,
  input  logic        bmu_tt_trans_cmplt,
  input  logic        bmu_tt_acc_err,
  input  logic [31:0] bmu_tt_rdata,
  output logic        tt_bmu_req,
  output logic        tt_bmu_data_req,
  output logic        tt_bmu_write,
  output logic        tt_bmu_seq,
  output logic        tt_bmu_acc_deny,
  output logic [31:0] tt_bmu_addr,
  output logic [3:0]  tt_bmu_prot,
  output logic [1:0]  tt_bmu_size,
  output logic [2:0]  tt_bmu_burst,
  output logic [31:0] tt_bmu_wdata,
  output logic        bmu_ifu_grnt,
  output logic        bmu_ifu_trans_cmplt,
  output logic        bmu_ifu_acc_err,
  output logic [31:0] bmu_ifu_rdata,
  output logic        bmu_lsu_grnt,
  output logic        bmu_lsu_trans_cmplt,
  output logic        bmu_lsu_acc_err,
  output logic [31:0] bmu_lsu_rdata,
  output logic [3:0]  arb_dbginfo
);

  localparam logic       OwnIfu     = 1'b0;
  localparam logic       OwnLsu     = 1'b1;
  localparam logic [2:0] BurstIncr4 = 3'b011;
  localparam logic [3:0] StarveMax  = 4'(LSU_MAX_CONSEC);

  logic       pend_vld;
  logic       pend_owner;
  logic       data_vld;
  logic       data_owner;
  logic       lock_vld;
  logic       lock_owner;
  logic [1:0] beat_cnt;
  logic [3:0] starve_cnt;

  logic sel;
  logic sel_lsu;
  logic starve_sat;
  logic gnt;
  logic err_unlock;

  assign starve_sat = (starve_cnt == StarveMax);

  always_comb begin
    if (lock_vld) begin
      sel = lock_owner;
    end else if (pend_vld) begin
      sel = pend_owner;
    end else if (lsu_bmu_req && !(ifu_bmu_req && starve_sat)) begin
      sel = OwnLsu;
    end else begin
      sel = OwnIfu;
    end
  end

  assign sel_lsu = (sel == OwnLsu);

  assign tt_bmu_req      = sel_lsu ? lsu_bmu_req   : ifu_bmu_req;
  assign tt_bmu_addr     = sel_lsu ? lsu_bmu_addr  : ifu_bmu_addr;
  assign tt_bmu_prot     = sel_lsu ? lsu_bmu_prot  : ifu_bmu_prot;
  assign tt_bmu_size     = sel_lsu ? lsu_bmu_size  : ifu_bmu_size;
  assign tt_bmu_burst    = sel_lsu ? lsu_bmu_burst : ifu_bmu_burst;
  assign tt_bmu_seq      = sel_lsu ? lsu_bmu_seq   : ifu_bmu_seq;
  assign tt_bmu_write    = sel_lsu & lsu_bmu_write;
  assign tt_bmu_acc_deny = sel_lsu & lsu_bmu_acc_deny;

  assign gnt          = bmu_tt_grant & tt_bmu_req;
  assign bmu_ifu_grnt = gnt & ~sel_lsu;
  assign bmu_lsu_grnt = gnt & sel_lsu;

  assign tt_bmu_data_req = data_vld;
  assign tt_bmu_wdata    = (data_owner == OwnLsu) ? lsu_bmu_wdata : 32'h0;

  assign bmu_ifu_trans_cmplt = bmu_tt_trans_cmplt & (data_owner == OwnIfu);
  assign bmu_ifu_acc_err     = bmu_tt_acc_err & (data_owner == OwnIfu);
  assign bmu_ifu_rdata       = (data_owner == OwnIfu) ? bmu_tt_rdata : 32'h0;
  assign bmu_lsu_trans_cmplt = bmu_tt_trans_cmplt & (data_owner == OwnLsu);
  assign bmu_lsu_acc_err     = bmu_tt_acc_err & (data_owner == OwnLsu);
  assign bmu_lsu_rdata       = (data_owner == OwnLsu) ? bmu_tt_rdata : 32'h0;

  assign arb_dbginfo = {lock_vld, pend_vld, data_vld, data_owner};

  // A failed beat of the locked burst releases the bus without waiting for the remaining beats.
  assign err_unlock = lock_vld & data_vld & bmu_tt_trans_cmplt & bmu_tt_acc_err &
                      (data_owner == lock_owner);

  always_ff @(posedge bmu_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      pend_vld   <= 1'b0;
      pend_owner <= 1'b0;
      data_vld   <= 1'b0;
      data_owner <= 1'b0;
      lock_vld   <= 1'b0;
      lock_owner <= 1'b0;
      beat_cnt   <= 2'd0;
      starve_cnt <= 4'd0;
    end else begin
      if (gnt) begin
        pend_vld <= 1'b0;
      end else if (tt_bmu_req) begin
        pend_vld   <= 1'b1;
        pend_owner <= sel;
      end

      if (gnt) begin
        data_vld   <= 1'b1;
        data_owner <= sel;
      end else if (bmu_tt_trans_cmplt) begin
        data_vld <= 1'b0;
      end

      if (err_unlock) begin
        lock_vld <= 1'b0;
        beat_cnt <= 2'd0;
      end else if (gnt) begin
        if (lock_vld) begin
          if (beat_cnt == 2'd1) begin
            lock_vld <= 1'b0;
          end
          beat_cnt <= beat_cnt - 2'd1;
        end else if (tt_bmu_burst == BurstIncr4) begin
          lock_vld   <= 1'b1;
          lock_owner <= sel;
          beat_cnt   <= 2'd3;
        end
      end

      if (!ifu_bmu_req || bmu_ifu_grnt) begin
        starve_cnt <= 4'd0;
      end else if (bmu_lsu_grnt && !lock_vld && !starve_sat) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_pa_bmu_req_arb.sv
// Bench for pa_bmu_req_arb: directed vector table, hand sequences for burst/error/reset corners,
// then constrained-random traffic against a transaction-level reference model.
module tb_pa_bmu_req_arb;

  localparam int unsigned MaxConsec = 4;
  localparam logic [31:0] AddrI = 32'h0000_1000;
  localparam logic [31:0] AddrL = 32'h0000_2000;
  localparam logic [31:0] RdD   = 32'hCAFE_0001;

  logic        bmu_clk = 1'b0;
  logic        cpurst_b;
  logic        ifu_bmu_req, ifu_bmu_seq;
  logic [31:0] ifu_bmu_addr;
  logic [3:0]  ifu_bmu_prot;
  logic [1:0]  ifu_bmu_size;
  logic [2:0]  ifu_bmu_burst;
  logic        lsu_bmu_req, lsu_bmu_seq, lsu_bmu_write, lsu_bmu_acc_deny;
  logic [31:0] lsu_bmu_addr, lsu_bmu_wdata;
  logic [3:0]  lsu_bmu_prot;
  logic [1:0]  lsu_bmu_size;
  logic [2:0]  lsu_bmu_burst;
  logic        bmu_tt_grant, bmu_tt_trans_cmplt, bmu_tt_acc_err;
  logic [31:0] bmu_tt_rdata;
  logic        tt_bmu_req, tt_bmu_data_req, tt_bmu_write, tt_bmu_seq, tt_bmu_acc_deny;
  logic [31:0] tt_bmu_addr, tt_bmu_wdata;
  logic [3:0]  tt_bmu_prot;
  logic [1:0]  tt_bmu_size;
  logic [2:0]  tt_bmu_burst;
  logic        bmu_ifu_grnt, bmu_ifu_trans_cmplt, bmu_ifu_acc_err;
  logic [31:0] bmu_ifu_rdata;
  logic        bmu_lsu_grnt, bmu_lsu_trans_cmplt, bmu_lsu_acc_err;
  logic [31:0] bmu_lsu_rdata;
  logic [3:0]  arb_dbginfo;

  pa_bmu_req_arb #(.LSU_MAX_CONSEC(MaxConsec)) dut (
    .bmu_clk(bmu_clk), .cpurst_b(cpurst_b),
    .ifu_bmu_req(ifu_bmu_req), .ifu_bmu_addr(ifu_bmu_addr), .ifu_bmu_prot(ifu_bmu_prot),
    .ifu_bmu_size(ifu_bmu_size), .ifu_bmu_burst(ifu_bmu_burst), .ifu_bmu_seq(ifu_bmu_seq),
    .lsu_bmu_req(lsu_bmu_req), .lsu_bmu_addr(lsu_bmu_addr), .lsu_bmu_prot(lsu_bmu_prot),
    .lsu_bmu_size(lsu_bmu_size), .lsu_bmu_burst(lsu_bmu_burst), .lsu_bmu_seq(lsu_bmu_seq),
    .lsu_bmu_write(lsu_bmu_write), .lsu_bmu_wdata(lsu_bmu_wdata),
    .lsu_bmu_acc_deny(lsu_bmu_acc_deny),
    .bmu_tt_grant(bmu_tt_grant), .bmu_tt_trans_cmplt(bmu_tt_trans_cmplt),
    .bmu_tt_acc_err(bmu_tt_acc_err), .bmu_tt_rdata(bmu_tt_rdata),
    .tt_bmu_req(tt_bmu_req), .tt_bmu_data_req(tt_bmu_data_req), .tt_bmu_write(tt_bmu_write),
    .tt_bmu_seq(tt_bmu_seq), .tt_bmu_acc_deny(tt_bmu_acc_deny), .tt_bmu_addr(tt_bmu_addr),
    .tt_bmu_prot(tt_bmu_prot), .tt_bmu_size(tt_bmu_size), .tt_bmu_burst(tt_bmu_burst),
    .tt_bmu_wdata(tt_bmu_wdata),
    .bmu_ifu_grnt(bmu_ifu_grnt), .bmu_ifu_trans_cmplt(bmu_ifu_trans_cmplt),
    .bmu_ifu_acc_err(bmu_ifu_acc_err), .bmu_ifu_rdata(bmu_ifu_rdata),
    .bmu_lsu_grnt(bmu_lsu_grnt), .bmu_lsu_trans_cmplt(bmu_lsu_trans_cmplt),
    .bmu_lsu_acc_err(bmu_lsu_acc_err), .bmu_lsu_rdata(bmu_lsu_rdata),
    .arb_dbginfo(arb_dbginfo)
  );

  always #5 bmu_clk = ~bmu_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: owners as ints (-1 = none), lock as a count of remaining locked grants.
  int m_pend, m_dat, m_lock_left, m_lock_own, m_streak;
  int e_own;
  bit e_req, e_gnt, e_ig, e_lg;

  task automatic model_reset();
    m_pend = -1; m_dat = -1; m_lock_left = 0; m_lock_own = 0; m_streak = 0;
  endtask

  task automatic model_outputs();
    if (m_lock_left > 0) e_own = m_lock_own;
    else if (m_pend >= 0) e_own = m_pend;
    else if (lsu_bmu_req && !(ifu_bmu_req && m_streak == int'(MaxConsec))) e_own = 1;
    else e_own = 0;
    e_req = (e_own == 1) ? lsu_bmu_req : ifu_bmu_req;
    e_gnt = bmu_tt_grant && e_req;
    e_ig  = e_gnt && (e_own == 0);
    e_lg  = e_gnt && (e_own == 1);
  endtask

  task automatic model_commit();
    bit locked;
    logic [2:0] b;
    locked = (m_lock_left > 0);
    b = (e_own == 1) ? lsu_bmu_burst : ifu_bmu_burst;
    if (locked && bmu_tt_trans_cmplt && bmu_tt_acc_err && m_dat == m_lock_own) m_lock_left = 0;
    else if (e_gnt) begin
      if (locked) m_lock_left--;
      else if (b == 3'b011) begin m_lock_left = 3; m_lock_own = e_own; end
    end
    if (!ifu_bmu_req || e_ig) m_streak = 0;
    else if (e_lg && !locked && m_streak < int'(MaxConsec)) m_streak++;
    if (e_gnt) m_pend = -1;
    else if (e_req) m_pend = e_own;
    if (e_gnt) m_dat = e_own;
    else if (bmu_tt_trans_cmplt) m_dat = -1;
  endtask

  task automatic clear_inputs();
    ifu_bmu_req = 0; ifu_bmu_addr = AddrI; ifu_bmu_prot = 4'h3; ifu_bmu_size = 2'd2;
    ifu_bmu_burst = 3'b000; ifu_bmu_seq = 0;
    lsu_bmu_req = 0; lsu_bmu_addr = AddrL; lsu_bmu_prot = 4'h1; lsu_bmu_size = 2'd2;
    lsu_bmu_burst = 3'b000; lsu_bmu_seq = 0; lsu_bmu_write = 0; lsu_bmu_wdata = 32'h0;
    lsu_bmu_acc_deny = 0;
    bmu_tt_grant = 0; bmu_tt_trans_cmplt = 0; bmu_tt_acc_err = 0; bmu_tt_rdata = 32'h0;
  endtask

  task automatic do_reset();
    clear_inputs();
    cpurst_b = 0;
    repeat (2) @(posedge bmu_clk);
    #1 cpurst_b = 1;
    model_reset();
    @(negedge bmu_clk);
    chk("reset_dbg", 64'(arb_dbginfo), 64'h0);
    chk("reset_data_req", 64'(tt_bmu_data_req), 64'h0);
    @(posedge bmu_clk); #1;
  endtask

  task automatic next_cycle();
    @(posedge bmu_clk); #1;
  endtask

  // stim {ifu_req, lsu_req, lsu_incr4, grant, cmplt, err}
  // exp  {tt_req, ifu_grnt, lsu_grnt, ifu_cmplt, lsu_cmplt, ifu_err, lsu_err}
  typedef struct packed {
    logic [5:0]  stim;
    logic [6:0]  exp;
    logic [31:0] addr;
    logic [31:0] irdata;
    logic [31:0] lrdata;
    logic [3:0]  dbg;
  } vec_t;

  vec_t tbl [14];
  logic [9:0] lsu_pat;
  bit ig_now, lg_now;

  initial begin
    tbl[0]  = '{6'b100100, 7'b1100000, AddrI, 32'h0, 32'h0, 4'h0};
    tbl[1]  = '{6'b000010, 7'b0001000, AddrI, RdD,   32'h0, 4'h2};
    tbl[2]  = '{6'b110000, 7'b1000000, AddrL, 32'h0, 32'h0, 4'h0};
    tbl[3]  = '{6'b110000, 7'b1000000, AddrL, 32'h0, 32'h0, 4'h4};
    tbl[4]  = '{6'b110000, 7'b1000000, AddrL, 32'h0, 32'h0, 4'h4};
    tbl[5]  = '{6'b110100, 7'b1010000, AddrL, 32'h0, 32'h0, 4'h4};
    tbl[6]  = '{6'b100110, 7'b1100100, AddrI, 32'h0, RdD,   4'h3};
    tbl[7]  = '{6'b000010, 7'b0001000, AddrI, RdD,   32'h0, 4'h2};
    tbl[8]  = '{6'b111100, 7'b1010000, AddrL, 32'h0, 32'h0, 4'h0};
    tbl[9]  = '{6'b111110, 7'b1010100, AddrL, 32'h0, RdD,   4'hB};
    tbl[10] = '{6'b111110, 7'b1010100, AddrL, 32'h0, RdD,   4'hB};
    tbl[11] = '{6'b111110, 7'b1010100, AddrL, 32'h0, RdD,   4'hB};
    tbl[12] = '{6'b100110, 7'b1100100, AddrI, 32'h0, RdD,   4'h3};
    tbl[13] = '{6'b000010, 7'b0001000, AddrI, RdD,   32'h0, 4'h2};

    do_reset();
    for (int i = 0; i < 14; i++) begin
      ifu_bmu_req        = tbl[i].stim[5];
      lsu_bmu_req        = tbl[i].stim[4];
      lsu_bmu_burst      = tbl[i].stim[3] ? 3'b011 : 3'b000;
      bmu_tt_grant       = tbl[i].stim[2];
      bmu_tt_trans_cmplt = tbl[i].stim[1];
      bmu_tt_acc_err     = tbl[i].stim[0];
      bmu_tt_rdata       = tbl[i].stim[1] ? RdD : 32'h0;
      @(negedge bmu_clk);
      chk($sformatf("vec%0d_ctrl", i),
          64'({tt_bmu_req, bmu_ifu_grnt, bmu_lsu_grnt, bmu_ifu_trans_cmplt,
               bmu_lsu_trans_cmplt, bmu_ifu_acc_err, bmu_lsu_acc_err}), 64'(tbl[i].exp));
      if (tbl[i].exp[6]) chk($sformatf("vec%0d_addr", i), 64'(tt_bmu_addr), 64'(tbl[i].addr));
      chk($sformatf("vec%0d_ifu_rdata", i), 64'(bmu_ifu_rdata), 64'(tbl[i].irdata));
      chk($sformatf("vec%0d_lsu_rdata", i), 64'(bmu_lsu_rdata), 64'(tbl[i].lrdata));
      chk($sformatf("vec%0d_dbg", i), 64'(arb_dbginfo), 64'(tbl[i].dbg));
      next_cycle();
    end

    // Both masters streaming SINGLE transfers: grant pattern LLLLI repeating.
    do_reset();
    lsu_pat = 10'b0111101111;
    ifu_bmu_req = 1; lsu_bmu_req = 1; bmu_tt_grant = 1;
    for (int i = 0; i < 10; i++) begin
      bmu_tt_trans_cmplt = (i != 0);
      @(negedge bmu_clk);
      chk($sformatf("starve_cyc%0d", i), 64'({bmu_ifu_grnt, bmu_lsu_grnt}),
          64'({~lsu_pat[i], lsu_pat[i]}));
      next_cycle();
    end

    // Access error on beat 2 of an IFU INCR4 releases the lock for a waiting LSU.
    do_reset();
    ifu_bmu_req = 1; ifu_bmu_burst = 3'b011; bmu_tt_grant = 1;
    @(negedge bmu_clk);
    chk("err_beat1_grnt", 64'({bmu_ifu_grnt, bmu_lsu_grnt}), 64'b10);
    next_cycle();
    lsu_bmu_req = 1; bmu_tt_trans_cmplt = 1;
    @(negedge bmu_clk);
    chk("err_beat2_grnt", 64'({bmu_ifu_grnt, bmu_lsu_grnt}), 64'b10);
    chk("err_beat2_dbg", 64'(arb_dbginfo), 64'hA);
    next_cycle();
    ifu_bmu_req = 0; bmu_tt_acc_err = 1;
    @(negedge bmu_clk);
    chk("err_pulse", 64'({bmu_ifu_acc_err, bmu_lsu_acc_err, bmu_ifu_trans_cmplt}), 64'b101);
    chk("err_lsu_blocked", 64'(bmu_lsu_grnt), 64'h0);
    next_cycle();
    bmu_tt_acc_err = 0; bmu_tt_trans_cmplt = 0;
    @(negedge bmu_clk);
    chk("err_lsu_grnt", 64'({bmu_ifu_grnt, bmu_lsu_grnt}), 64'b01);
    chk("err_unlocked_dbg", 64'(arb_dbginfo), 64'h0);
    next_cycle();

    // Reset asserted mid-burst with a data phase outstanding.
    do_reset();
    ifu_bmu_req = 1; ifu_bmu_burst = 3'b011; bmu_tt_grant = 1;
    next_cycle();
    ifu_bmu_req = 0; bmu_tt_grant = 0;
    @(negedge bmu_clk);
    chk("rst_pre_dbg", 64'(arb_dbginfo), 64'hA);
    chk("rst_pre_data_req", 64'(tt_bmu_data_req), 64'h1);
    cpurst_b = 0;
    #1;
    chk("rst_async_data_req", 64'(tt_bmu_data_req), 64'h0);
    chk("rst_async_dbg", 64'(arb_dbginfo), 64'h0);
    next_cycle();
    cpurst_b = 1;
    ifu_bmu_req = 1; lsu_bmu_req = 1; ifu_bmu_burst = 3'b000; bmu_tt_grant = 1;
    @(negedge bmu_clk);
    chk("rst_fresh_arb", 64'({bmu_ifu_grnt, bmu_lsu_grnt}), 64'b01);
    next_cycle();

    // Random traffic; requesters hold requests and attributes until granted.
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge bmu_clk);
      model_outputs();
      chk("rnd_ctrl",
          64'({tt_bmu_req, bmu_ifu_grnt, bmu_lsu_grnt, tt_bmu_data_req, bmu_ifu_trans_cmplt,
               bmu_lsu_trans_cmplt, bmu_ifu_acc_err, bmu_lsu_acc_err, arb_dbginfo[3:1]}),
          64'({e_req, e_ig, e_lg, m_dat >= 0,
               bmu_tt_trans_cmplt && m_dat == 0, bmu_tt_trans_cmplt && m_dat == 1,
               bmu_tt_acc_err && m_dat == 0, bmu_tt_acc_err && m_dat == 1,
               m_lock_left > 0, m_pend >= 0, m_dat >= 0}));
      if (e_req) begin
        if (e_own == 1)
          chk("rnd_attr", 64'({tt_bmu_addr, tt_bmu_prot, tt_bmu_size, tt_bmu_burst, tt_bmu_seq,
                               tt_bmu_write, tt_bmu_acc_deny}),
              64'({lsu_bmu_addr, lsu_bmu_prot, lsu_bmu_size, lsu_bmu_burst, lsu_bmu_seq,
                   lsu_bmu_write, lsu_bmu_acc_deny}));
        else
          chk("rnd_attr", 64'({tt_bmu_addr, tt_bmu_prot, tt_bmu_size, tt_bmu_burst, tt_bmu_seq,
                               tt_bmu_write, tt_bmu_acc_deny}),
              64'({ifu_bmu_addr, ifu_bmu_prot, ifu_bmu_size, ifu_bmu_burst, ifu_bmu_seq,
                   2'b00}));
      end
      if (m_dat >= 0) begin
        chk("rnd_owner", 64'(arb_dbginfo[0]), 64'(m_dat == 1));
        chk("rnd_rdata", 64'({bmu_ifu_rdata, bmu_lsu_rdata}),
            64'({(m_dat == 0) ? bmu_tt_rdata : 32'h0, (m_dat == 1) ? bmu_tt_rdata : 32'h0}));
        chk("rnd_wdata", 64'(tt_bmu_wdata), 64'((m_dat == 1) ? lsu_bmu_wdata : 32'h0));
      end
      ig_now = e_ig;
      lg_now = e_lg;
      model_commit();
      next_cycle();
      if (!ifu_bmu_req || ig_now) begin
        ifu_bmu_req   = 1'($urandom_range(0, 1));
        ifu_bmu_addr  = $urandom;
        ifu_bmu_prot  = 4'($urandom);
        ifu_bmu_size  = 2'($urandom);
        ifu_bmu_seq   = 1'($urandom);
        ifu_bmu_burst = ($urandom_range(0, 3) == 0) ? 3'b011 : 3'b000;
      end
      if (!lsu_bmu_req || lg_now) begin
        lsu_bmu_req      = 1'($urandom_range(0, 1));
        lsu_bmu_addr     = $urandom;
        lsu_bmu_prot     = 4'($urandom);
        lsu_bmu_size     = 2'($urandom);
        lsu_bmu_seq      = 1'($urandom);
        lsu_bmu_write    = 1'($urandom);
        lsu_bmu_acc_deny = 1'($urandom);
        lsu_bmu_burst    = ($urandom_range(0, 3) == 0) ? 3'b011 : 3'b000;
      end
      lsu_bmu_wdata      = $urandom;
      bmu_tt_grant       = ($urandom_range(0, 9) < 6);
      bmu_tt_trans_cmplt = (m_dat >= 0) && ($urandom_range(0, 9) < 6);
      bmu_tt_acc_err     = bmu_tt_trans_cmplt && ($urandom_range(0, 4) == 0);
      bmu_tt_rdata       = $urandom;
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
